// File: rtl/rr_pipe_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_pipe_mux_pkg
// Shared constants and helpers for the rr_pipe_mux block.
//   MODE_FIXED / MODE_RR : values of the mode input
//   wrap_idx()           : modulo wrap of a channel index (n must be >= 1)
// Optional feature macro used by the block: RR_PIPE_MUX_LOCK_EN
// -----------------------------------------------------------------------------
package rr_pipe_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wraps an index into 0..n-1. The n <= 1 guard keeps a degenerate channel
  // count from producing a divide-by-zero during elaboration.
  function automatic int wrap_idx(input int idx, input int n);
    if (n <= 1) begin
      return 0;
    end
    return idx % n;
  endfunction

endpackage : rr_pipe_mux_pkg

// File: rtl/rr_pipe_mux_if.sv
// -----------------------------------------------------------------------------
// rr_pipe_mux_if
// Bundles the producer-side and consumer-side handshake of rr_pipe_mux.
//   mode      : 0 = fixed select via ctrl, 1 = round-robin
//   ctrl      : channel index used in fixed mode
//   in_valid  : per-channel valid            in_data : N*T packed channel data
//   in_ready  : per-channel accept           in_last : packet end (lock build)
//   out_valid : output register holds data   out_data/out_sel : beat and source
//   out_ready : consumer accept
// Modports: slave = the mux itself, master = the environment driving it.
// Optional port in_last exists only when RR_PIPE_MUX_LOCK_EN is defined.
// -----------------------------------------------------------------------------
interface rr_pipe_mux_if #(
  parameter int S = 3,
  parameter int T = 8
);
  localparam int N = 2**S;

  logic           mode;
  logic [S-1:0]   ctrl;
  logic [N-1:0]   in_valid;
  logic [N*T-1:0] in_data;
  logic [N-1:0]   in_ready;
`ifdef RR_PIPE_MUX_LOCK_EN
  logic [N-1:0]   in_last;
`endif
  logic           out_valid;
  logic [T-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_ready;

  modport slave (
    input  mode, ctrl, in_valid, in_data,
`ifdef RR_PIPE_MUX_LOCK_EN
    input  in_last,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output mode, ctrl, in_valid, in_data,
`ifdef RR_PIPE_MUX_LOCK_EN
    output in_last,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface : rr_pipe_mux_if

// File: rtl/rr_pipe_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational channel selector for rr_pipe_mux.
//   i_mode   : MODE_FIXED selects i_ctrl, MODE_RR scans from i_rr_ptr
//   i_ctrl   : fixed-mode channel index
//   i_rr_ptr : first channel examined in round-robin mode
//   i_valid  : per-channel request
//   o_grant  : one-hot grant (all zero when nothing is granted)
//   o_idx    : encoded index of the granted channel (don't-care if !o_any)
//   o_any    : a grant exists
// -----------------------------------------------------------------------------
module rr_arbiter
  import rr_pipe_mux_pkg::*;
#(
  parameter int S = 3
) (
  input  logic              i_mode,
  input  logic [S-1:0]      i_ctrl,
  input  logic [S-1:0]      i_rr_ptr,
  input  logic [2**S-1:0]   i_valid,
  output logic [2**S-1:0]   o_grant,
  output logic [S-1:0]      o_idx,
  output logic              o_any
);
  localparam int N = 2**S;

  logic [S-1:0] w_rr_idx;
  logic         w_rr_any;
  logic [S-1:0] w_cand;

  // Scan from the farthest offset back towards rr_ptr so that the last hit
  // written is the closest requester at or after the pointer.
  always_comb begin
    w_rr_idx = '0;
    w_rr_any = 1'b0;
    w_cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = S'(wrap_idx(int'(i_rr_ptr) + k, N));
      if (i_valid[w_cand]) begin
        w_rr_idx = w_cand;
        w_rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    if (i_mode == MODE_RR) begin
      o_idx = w_rr_idx;
      o_any = w_rr_any;
    end else begin
      o_idx = i_ctrl;
      o_any = i_valid[i_ctrl];
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grant[gi] = o_any && (o_idx == S'(gi));
    end
  endgenerate

endmodule : rr_arbiter

// File: rtl/rr_pipe_mux.sv
// -----------------------------------------------------------------------------
// rr_pipe_mux
// 2^S-channel, T-bit valid/ready multiplexer with a single registered output
// entry. The channel is chosen by ctrl (fixed mode) or a round-robin pointer.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_pipe_mux_if.slave (mode, ctrl, in_*, out_*)
// Optional feature: define RR_PIPE_MUX_LOCK_EN to add in_last and packet
// locking (grant sticks to a channel until its last beat transfers, and the
// round-robin pointer only advances on last beats).
// -----------------------------------------------------------------------------
module rr_pipe_mux
  import rr_pipe_mux_pkg::*;
#(
  parameter int S = 3,
  parameter int T = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_pipe_mux_if.slave bus
);
  localparam int N = 2**S;

  // Unpacked view of the channel bus so the data select is a plain index.
  logic [T-1:0] w_ch_data [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_ch_data[gi] = bus.in_data[gi*T +: T];
    end
  endgenerate

  logic         r_out_valid;
  logic [T-1:0] r_out_data;
  logic [S-1:0] r_out_sel;
  logic [S-1:0] r_rr_ptr;

  logic         w_arb_mode;
  logic [S-1:0] w_arb_ctrl;
  logic [N-1:0] w_grant;
  logic [S-1:0] w_idx;
  logic         w_any;
  logic         w_free;
  logic         w_xfer;
  logic         w_last;
  logic [S-1:0] w_ptr_next;

`ifdef RR_PIPE_MUX_LOCK_EN
  logic         r_locked;
  logic [S-1:0] r_lock_idx;

  // A locked packet is served exactly like a fixed-mode select on the
  // owning channel, which keeps the arbiter itself lock-agnostic.
  assign w_arb_mode = r_locked ? MODE_FIXED : bus.mode;
  assign w_arb_ctrl = r_locked ? r_lock_idx : bus.ctrl;
  assign w_last     = bus.in_last[w_idx];
`else
  assign w_arb_mode = bus.mode;
  assign w_arb_ctrl = bus.ctrl;
  assign w_last     = 1'b1;
`endif

  rr_arbiter #(
    .S (S)
  ) u_arbiter (
    .i_mode   (w_arb_mode),
    .i_ctrl   (w_arb_ctrl),
    .i_rr_ptr (r_rr_ptr),
    .i_valid  (bus.in_valid),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // The single output entry can take a new beat when empty or when it is
  // being drained in this same cycle.
  assign w_free     = ~r_out_valid | bus.out_ready;
  assign w_xfer     = w_any & w_free;
  assign w_ptr_next = S'(wrap_idx(int'(w_idx) + 1, N));

  assign bus.in_ready  = w_grant & {N{w_free}};
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

  // Output register: load on transfer, otherwise clear valid on drain while
  // data and sel hold their last values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_idx];
      r_out_sel   <= w_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the channel that just completed a
  // transfer (a whole packet in the lock build), in either mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer && w_last) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

`ifdef RR_PIPE_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      r_locked   <= ~w_last;
      r_lock_idx <= w_idx;
    end
  end
`endif

endmodule : rr_pipe_mux

// File: tb/tb_rr_pipe_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_pipe_mux
// Self-checking bench for rr_pipe_mux with S=2, T=8. A reference model
// predicts in_ready each cycle and pushes every accepted beat into a
// scoreboard queue; the head of the queue is what the output register must
// show. Inputs change 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_rr_pipe_mux;

  localparam int S = 2;
  localparam int T = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [T-1:0] data;
    logic [S-1:0] sel;
  } beat_t;

  logic clk;
  logic rst_n;

  rr_pipe_mux_if #(.S(S), .T(T)) bus ();

  rr_pipe_mux #(.S(S), .T(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  beat_t        exp_q[$];
  logic         m_valid;
  logic [S-1:0] m_ptr;
  logic         m_locked;
  logic [S-1:0] m_lock_idx;

  // ---------------------------------------------------------------- model
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] g;
    logic [S-1:0] c;
    g = '0;
    if (m_locked) begin
      g[m_lock_idx] = bus.in_valid[m_lock_idx];
    end else if (bus.mode == 1'b0) begin
      g[bus.ctrl] = bus.in_valid[bus.ctrl];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        c = m_ptr + 2'(k);
        if (bus.in_valid[c]) begin
          g    = '0;
          g[c] = 1'b1;
        end
      end
    end
    if (m_valid && !bus.out_ready) g = '0;
    return g;
  endfunction

  task automatic model_update();
    logic [N-1:0] r;
    int           idx;
    beat_t        b;
    logic         last;
    r = model_ready();
    if (r != '0) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (r[k]) idx = k;
      if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      b.data = bus.in_data[idx*T +: T];
      b.sel  = 2'(idx);
      exp_q.push_back(b);
      m_valid = 1'b1;
      last = 1'b1;
`ifdef RR_PIPE_MUX_LOCK_EN
      last       = bus.in_last[idx];
      m_locked   = ~last;
      m_lock_idx = 2'(idx);
`endif
      if (last) m_ptr = 2'(idx + 1);
    end else if (m_valid && bus.out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid    = 1'b0;
    m_ptr      = '0;
    m_locked   = 1'b0;
    m_lock_idx = '0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.ctrl      = '0;
    bus.in_valid  = '0;
    bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.out_ready = 1'b0;
`ifdef RR_PIPE_MUX_LOCK_EN
    bus.in_last   = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_data !== 8'h00) $display("FAIL reset_data got=%h want=00", bus.out_data);
    else n_pass++;
    n_total++;
    if (bus.out_sel !== 2'd0) $display("FAIL reset_sel got=%0d want=0", bus.out_sel);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 4'b0000) $display("FAIL reset_ready got=%b want=0000", bus.in_ready);
    else n_pass++;
    $display("reset: valid=%b data=%h sel=%0d", bus.out_valid, bus.out_data, bus.out_sel);
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic test_fixed();
    logic [N-1:0] er;
    do_reset();
    bus.mode = 1'b0; bus.ctrl = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      er = model_ready();
      n_total++;
      if (bus.in_ready !== er || bus.in_ready !== 4'b0100)
        $display("FAIL fixed_ready cyc=%0d got=%b want=0100", i, bus.in_ready);
      else n_pass++;
      n_total++;
      if (bus.out_valid !== m_valid)
        $display("FAIL fixed_valid cyc=%0d got=%b want=%b", i, bus.out_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if (bus.out_data !== exp_q[0].data || bus.out_sel !== exp_q[0].sel ||
            bus.out_data !== 8'h12 || bus.out_sel !== 2'd2)
          $display("FAIL fixed_beat cyc=%0d got=%h/%0d want=12/2", i, bus.out_data, bus.out_sel);
        else n_pass++;
      end
      $display("fixed cyc=%0d ready=%b valid=%b data=%h sel=%0d",
               i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      model_update();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rr();
    logic [N-1:0] er;
    do_reset();
    bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      er = model_ready();
      n_total++;
      if (bus.in_ready !== er) $display("FAIL rr_ready cyc=%0d got=%b want=%b", i, bus.in_ready, er);
      else n_pass++;
      n_total++;
      if (bus.out_valid !== (i > 0)) $display("FAIL rr_valid cyc=%0d got=%b want=%b", i, bus.out_valid, i > 0);
      else n_pass++;
      if (i > 0 && exp_q.size() > 0) begin
        n_total++;
        if (bus.out_sel !== 2'((i - 1) % 4) || bus.out_sel !== exp_q[0].sel || bus.out_data !== exp_q[0].data)
          $display("FAIL rr_beat cyc=%0d got=%h/%0d want=%h/%0d", i, bus.out_data, bus.out_sel,
                   exp_q[0].data, (i - 1) % 4);
        else n_pass++;
      end
      $display("rr cyc=%0d ready=%b valid=%b data=%h sel=%0d",
               i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      model_update();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] er;
    do_reset();
    bus.mode = 1'b0; bus.ctrl = 2'd1; bus.in_valid = 4'b0010;
    bus.in_data = {8'h13, 8'h12, 8'hAA, 8'h10}; bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin bus.out_ready = 1'b0; bus.in_data = {8'h13, 8'h12, 8'hBB, 8'h10}; end
      if (i == 4) bus.out_ready = 1'b1;
      if (i == 5) bus.in_valid = 4'b0000;
      @(negedge clk);
      er = model_ready();
      n_total++;
      if (bus.in_ready !== er) $display("FAIL bp_ready cyc=%0d got=%b want=%b", i, bus.in_ready, er);
      else n_pass++;
      if (i >= 1 && i <= 3) begin
        n_total++;
        if (bus.in_ready !== 4'b0000 || bus.out_data !== 8'hAA || bus.out_valid !== 1'b1)
          $display("FAIL bp_stall cyc=%0d got=%b/%h want=0000/aa", i, bus.in_ready, bus.out_data);
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if (bus.in_ready !== 4'b0010) $display("FAIL bp_reload got=%b want=0010", bus.in_ready);
        else n_pass++;
      end
      if (i == 5) begin
        n_total++;
        if (bus.out_data !== 8'hBB) $display("FAIL bp_next got=%h want=bb", bus.out_data);
        else n_pass++;
      end
      if (m_valid) begin
        n_total++;
        if (bus.out_data !== exp_q[0].data || bus.out_sel !== exp_q[0].sel)
          $display("FAIL bp_beat cyc=%0d got=%h/%0d want=%h/%0d", i, bus.out_data, bus.out_sel,
                   exp_q[0].data, exp_q[0].sel);
        else n_pass++;
      end
      n_total++;
      if (bus.out_valid !== m_valid) $display("FAIL bp_valid cyc=%0d got=%b want=%b", i, bus.out_valid, m_valid);
      else n_pass++;
      $display("bp cyc=%0d ready=%b valid=%b data=%h sel=%0d",
               i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      model_update();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sparse();
    logic [N-1:0] er;
    logic [N-1:0] want [4];
    want[0] = 4'b0100; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b0010;
    do_reset();
    bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.in_valid = 4'b0110;
      if (i == 4) bus.in_valid = 4'b0000;
      @(negedge clk);
      er = model_ready();
      n_total++;
      if (bus.in_ready !== er || (i < 4 && bus.in_ready !== want[i]))
        $display("FAIL sparse_ready cyc=%0d got=%b want=%b", i, bus.in_ready, er);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if (bus.out_sel !== exp_q[0].sel || bus.out_data !== exp_q[0].data)
          $display("FAIL sparse_beat cyc=%0d got=%h/%0d want=%h/%0d", i, bus.out_data, bus.out_sel,
                   exp_q[0].data, exp_q[0].sel);
        else n_pass++;
      end
      $display("sparse cyc=%0d ready=%b valid=%b data=%h sel=%0d",
               i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      model_update();
      @(posedge clk); #1;
    end
  endtask

`ifdef RR_PIPE_MUX_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] er;
    do_reset();
    // First beat of channel 1 via fixed select, then switch to round-robin
    // with ctrl pointing elsewhere: the lock must keep channel 1.
    bus.mode = 1'b0; bus.ctrl = 2'd1; bus.in_valid = 4'b0011; bus.out_ready = 1'b1;
    bus.in_last = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus.mode = 1'b1; bus.ctrl = 2'd0; end
      if (i == 2) bus.in_last = 4'b0011;
      @(negedge clk);
      er = model_ready();
      n_total++;
      if (bus.in_ready !== er || (i < 3 && bus.in_ready !== 4'b0010) || (i == 3 && bus.in_ready !== 4'b0001))
        $display("FAIL lock_ready cyc=%0d got=%b want=%b", i, bus.in_ready, er);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if (bus.out_sel !== exp_q[0].sel) $display("FAIL lock_sel cyc=%0d got=%0d want=%0d", i, bus.out_sel, exp_q[0].sel);
        else n_pass++;
      end
      $display("lock cyc=%0d ready=%b valid=%b sel=%0d", i, bus.in_ready, bus.out_valid, bus.out_sel);
      model_update();
      @(posedge clk); #1;
    end
    // Mid-packet reset: lock channel 1, reset, then round-robin from 0.
    do_reset();
    bus.mode = 1'b0; bus.ctrl = 2'd1; bus.in_valid = 4'b0010; bus.in_last = 4'b0000; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();
    bus.mode = 1'b1; bus.in_valid = 4'b0011; bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 4'b0001) $display("FAIL lock_reset got=%b want=0001", bus.in_ready);
    else n_pass++;
    $display("lock reset ready=%b", bus.in_ready);
    model_update();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_sparse();
`ifdef RR_PIPE_MUX_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_rr_pipe_mux

// File: doc/rr_pipe_mux.md
Name: rr_pipe_mux

Overview:
Parametrised 2^S-channel, T-bit-wide multiplexer with a per-channel valid/ready handshake and a registered output stage. The select comes from either a static ctrl input (fixed mode) or an internal round-robin arbiter (arbitrated mode). It is the sequential successor of the combinational tree mux and sits between several producers and one shared consumer, such as a bus or FIFO write port.

Parameters:
S, 3, select width; channel count N = 2**S (S >= 1)
T, 8, data width per channel in bits

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
mode  in  1  0 = fixed select via ctrl, 1 = round-robin arbitration
ctrl  in  S  channel index used in fixed mode
in_valid  in  N  per-channel data valid
in_data  in  N*T  channel k occupies bits [(k+1)*T-1 : k*T]
in_ready  out  N  per-channel accept
out_valid  out  1  output register holds data
out_data  out  T  registered data
out_sel  out  S  index of the channel that produced out_data
out_ready  in  1  consumer accept

Behaviour:
- Reset: when rst_n is low at a clk edge, out_valid=0, out_data=0, out_sel=0, rr_ptr=0. Any held beat is dropped, and reset takes priority over every other event.
- Slot free: free = ~out_valid | out_ready. The output register is a single entry and reloads in the same cycle that it is drained.
- Grant, fixed mode: grant = onehot(ctrl) & in_valid. Other channels always see in_ready=0.
- Grant, round-robin mode: grant goes to the first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N. With no requests there is no grant.
- in_ready: in_ready = grant & {N{free}}. At most one bit is set, and it is combinational from in_valid, mode, ctrl, rr_ptr and out_ready.
- Transfer: occurs when in_valid[g] & in_ready[g]. At that clk edge, out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Drain: if out_valid & out_ready with no new transfer, out_valid <= 0. out_data and out_sel hold their values.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sel stay stable and all in_ready are 0.
- Pointer: rr_ptr <= g+1 mod N after each transfer, in either mode. When g=N-1 it wraps to 0. With no transfer, rr_ptr holds.
- Mode/ctrl changes: both are sampled combinationally each cycle. A change never corrupts a beat already in the output register.
- Throughput: 1 beat per cycle when out_ready is held high.
- Width rules: all indices are S bits with natural modulo-N wrap, and no extra carry bit is kept.

Optional Feature:
RR_PIPE_MUX_LOCK_EN
- With the macro defined:
  - Adds input in_last[N]. After a transfer with in_last[g]=0, the grant locks to g in both modes, ignoring other requests and ctrl, until a transfer with in_last[g]=1.
  - rr_ptr advances only on a last beat.
  - Reset clears the lock.
- Without the macro: the in_last port does not exist, and arbitration is repeated on every beat.

Decomposition:
- Package rr_pipe_mux_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - Function clog2-safe index wrap.
- Sub-module rr_arbiter (params S), which takes in_valid, rr_ptr and mode/ctrl and produces a one-hot grant and an encoded index.
- The datapath select and the output register stay in the top module.

Test Plan:
- Reset then idle (S=2, T=8): after rst_n=0 for 2 cycles, out_valid=0, out_data=0x00, out_sel=0.
- Fixed mode, ctrl=2, all in_valid=1, in_data channels = 0x10,0x11,0x12,0x13, out_ready=1: out_data=0x12 and out_sel=2 every cycle; in_ready=4'b0100.
- Round-robin, all in_valid=1, out_ready=1 for 8 cycles: out_sel sequence is 0,1,2,3,0,1,2,3, and each beat appears 1 cycle after acceptance.
- Backpressure: a beat 0xAA is held with out_ready=0 for 3 cycles. out_data stays 0xAA and in_ready=0. When out_ready=1, the next beat loads in the same cycle.
- Sparse round-robin: with rr_ptr=3 and only channels 1 and 2 valid, channel 1 is granted, then channel 2, then channel 1 again.
- LOCK_EN: channel 1 sends 3 beats with in_last on the third while channel 0 is valid. out_sel=1,1,1, then 0; mid-packet reset clears the lock.
